uart_fifo_tx: RTL and testbench
===============================

# uart_fifo_tx

Buffered UART transmitter: accepts bytes from on-chip producers through a single-cycle write strobe, queues them in an internal FIFO and serialises them onto `txd` as 8N1 frames at a fixed baud divisor. It is the transmit-side counterpart of the `uart_rx` path and replaces the separate `uart_buf` plus read-FSM plus `uart_tx` arrangement at the top level. The block has one producer-facing write port and one serial output. It needs no external FIFO IP.

## Interface
- `BAUD_DIV`, 434: clock cycles per UART bit. 50 MHz / 115200 gives 434. Legal range 2..65535.
- `ADDR_W`, 4: FIFO address width. Depth is 2^ADDR_W entries (16 by default).
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_data` in 8: byte to enqueue.
- `wr_en` in 1: single-cycle write strobe. Accepted only when `full`=0.
- `full` out 1: FIFO holds 2^ADDR_W entries.
- `empty` out 1: FIFO holds 0 entries.
- `usedw` out ADDR_W+1: current FIFO occupancy, 0..2^ADDR_W.
- `overflow` out 1: sticky flag, set when `wr_en`=1 while `full`=1. Cleared only by `rst`.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `txd` out 1: serial output, registered. Idle level is 1.

## Operation
- FIFO:
  - Circular buffer with ADDR_W-bit read and write pointers that wrap modulo 2^ADDR_W.
  - `usedw`, `full` and `empty` are registered and derived from the occupancy counter.
  - Write occurs when `wr_en`=1 and the registered `full`=0. A write while `full`=1 is dropped, sets `overflow`, and leaves the contents unchanged.
  - A write and a pop in the same cycle leave `usedw` unchanged and advance both pointers.
  - A write in the same cycle as a pop while `full`=1 is still dropped, because `full` is sampled before the pop.
- FSM states are IDLE, LOAD, START, DATA, STOP.
  - IDLE: `txd`=1. If `empty`=0, assert pop (read pointer +1, occupancy −1) and go to LOAD. Otherwise stay in IDLE.
  - LOAD: latch the popped byte into an 8-bit shift register. Set `txd`<=0, clear the bit counter, go to START.
  - START: hold `txd`=0 for BAUD_DIV cycles. On the last cycle, drive `txd`<=shift[0] and go to DATA.
  - DATA: each bit is held for BAUD_DIV cycles, LSB first. After the 8th bit's last cycle, set `txd`<=1 and go to STOP.
  - STOP: hold `txd`=1 for BAUD_DIV cycles, then go to IDLE.
- The baud counter has width ceil(log2(BAUD_DIV)). It counts 0..BAUD_DIV−1 and resets to 0 on every state change.
- `busy` = (state != IDLE). It is registered with the state.

## Timing
- Reset values (on the first rising edge with `rst`=1):
  - `txd`=1, `busy`=0, `empty`=1, `full`=0, `usedw`=0, `overflow`=0.
  - FSM in IDLE, pointers at 0, FIFO contents discarded.
- Reset mid-frame: the frame is abandoned and `txd` is 1 from the edge after `rst` is sampled. No partial byte is retransmitted.
- Write to start-bit latency, with the write accepted at edge N into an empty, idle block:
  - `empty` falls after N.
  - IDLE pops at N+1.
  - LOAD drives `txd` low at N+2.
- Frame length from the `txd` falling edge to the end of the stop bit is exactly 10×BAUD_DIV cycles.
- Back-to-back bytes: after STOP ends, IDLE and LOAD add 2 cycles. The start-bit edges of consecutive frames are therefore 10×BAUD_DIV+2 cycles apart, and the stop level lasts BAUD_DIV+2 cycles.
- `wr_en` is never stalled. The producer checks `full` before writing; dropped bytes are reported only through `overflow`.
- `usedw` reflects an accepted write or a pop one edge after the event.

## Test plan
- Reset, then idle:
  - `txd`=1, `busy`=0, `empty`=1, `usedw`=0 for 100 cycles.
- Single byte, BAUD_DIV=8, write 0x55 at edge N:
  - `txd`=0 for cycles N+2..N+9.
  - Then bits 1,0,1,0,1,0,1,0, each 8 cycles.
  - Then stop=1.
  - `busy` falls at N+82.
- Burst of 0x48 0x65 0x6C 0x6C 0x6F ("Hello") on consecutive cycles:
  - `usedw` peaks at 4, because the first byte is popped immediately.
  - The decoded `txd` stream is the same 5 bytes in order.
  - Start edges are 82 cycles apart.
- Fill to full (ADDR_W=2, stalled during frame 1), then one more write:
  - `full`=1 and `usedw`=4.
  - The extra byte is absent from the output and `overflow`=1 stays set.
  - The 5 bytes accepted (the popped byte plus 4 queued) are sent in order.
- Simultaneous `wr_en` and pop at `usedw`=2:
  - `usedw` stays 2.
  - Pointer wrap after more than 2^ADDR_W total bytes produces no corruption.
- Assert `rst` during DATA bit 3 of 0xA5 with 2 bytes queued:
  - `txd`=1 from the next edge, `empty`=1, `overflow`=0.
  - No further frames are sent until new writes arrive.

Source files
------------

// File: rtl/uart_fifo_tx.sv
// Buffered 8N1 UART transmitter: circular-buffer FIFO feeding a bit-serialiser FSM.
module uart_fifo_tx #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   usedw,
  output logic              overflow,
  output logic              busy,
  output logic              txd
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t              state, state_next;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count_next;
  logic                wr_ok_c, pop_c, baud_last_c;
  logic [7:0]          pop_data, shift, shift_next;
  logic [2:0]          bit_cnt, bit_cnt_next;
  logic [BAUD_W-1:0]   baud_cnt, baud_next;
  logic                txd_next;

  // Occupancy update; full is the registered flag, so a write racing a pop while full is dropped
  always_comb begin
    wr_ok_c    = wr_en && !full;
    count_next = usedw;
    if (wr_ok_c && !pop_c)
      count_next = usedw + CNT_W'(1);
    else if (!wr_ok_c && pop_c)
      count_next = usedw - CNT_W'(1);
  end

  // FIFO pointers, occupancy and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      usedw    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_c)   rd_ptr <= rd_ptr + ADDR_W'(1);
      usedw <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // Storage array and popped-byte holding register (contents need no reset)
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr] <= wr_data;
    if (pop_c)   pop_data    <= mem[rd_ptr];
  end

  // Next-state and serial output logic
  always_comb begin
    state_next   = state;
    txd_next     = txd;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    baud_next    = baud_cnt + BAUD_W'(1);
    pop_c        = 1'b0;
    baud_last_c  = (baud_cnt == BAUD_W'(BAUD_DIV - 1));
    case (state)
      IDLE: begin
        txd_next  = 1'b1;
        baud_next = '0;
        if (!empty) begin
          pop_c      = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        shift_next   = pop_data;
        txd_next     = 1'b0;
        bit_cnt_next = '0;
        baud_next    = '0;
        state_next   = START;
      end
      START: begin
        if (baud_last_c) begin
          txd_next   = shift[0];
          shift_next = {1'b0, shift[7:1]};
          baud_next  = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_last_c) begin
          baud_next = '0;
          if (bit_cnt == 3'd7) begin
            txd_next   = 1'b1;
            state_next = STOP;
          end else begin
            txd_next     = shift[0];
            shift_next   = {1'b0, shift[7:1]};
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_last_c) begin
          baud_next  = '0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      busy     <= 1'b0;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else begin
      state    <= state_next;
      txd      <= txd_next;
      busy     <= (state_next != IDLE);
      shift    <= shift_next;
      bit_cnt  <= bit_cnt_next;
      baud_cnt <= baud_next;
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Scoreboard bench for uart_fifo_tx: writes push expected bytes, a txd decoder pops and compares.
module tb_uart_fifo_tx;

  localparam int BIT = 8;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          full, empty, overflow, busy, txd;
  logic [AW:0]   usedw;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rst_epoch = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_fifo_tx #(.BAUD_DIV(BIT), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .usedw(usedw), .overflow(overflow),
    .busy(busy), .txd(txd)
  );

  always #5 clk = ~clk;

  // Cycle counter and reset epoch, used by the decoder to time frames and abandon them on reset
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_epoch <= rst_epoch + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected txd k cycles after the write edge for a lone byte into an idle block
  function automatic logic exp_txd(input int k, input logic [7:0] b);
    int j;
    if (k < 2) return 1'b1;
    j = k - 2;
    if (j < BIT) return 1'b0;
    if (j < 9 * BIT) return b[(j - BIT) / BIT];
    return 1'b1;
  endfunction

  // Monitor: decode 8N1 frames at bit centres, compare against the scoreboard queue
  initial begin : monitor
    logic       prev;
    logic [7:0] b;
    int         ep;
    bit         ab;
    logic       s_start, s_stop;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && txd === 1'b0 && !rst) begin
        ep = rst_epoch;
        ab = 1'b0;
        start_q.push_back(cyc);
        b = '0;
        s_start = 1'b1;
        s_stop = 1'b0;
        for (int s = 1; s <= 9 * BIT + BIT / 2; s++) begin
          @(negedge clk);
          if (rst_epoch != ep) begin
            ab = 1'b1;
            break;
          end
          if (s == BIT / 2) s_start = txd;
          for (int i = 0; i < 8; i++)
            if (s == BIT * (i + 1) + BIT / 2) b[i] = txd;
          if (s == 9 * BIT + BIT / 2) s_stop = txd;
        end
        if (!ab) begin
          chk("start bit", 32'(s_start), 32'(1'b0));
          chk("stop bit", 32'(s_stop), 32'(1'b1));
          if (exp_q.size() == 0) begin
            chk("unexpected frame", 32'(b), 32'hFFFF_FFFF);
          end else begin
            chk("rx byte", 32'(b), 32'(exp_q.pop_front()));
          end
        end
      end
      prev = txd;
    end
  end

  task automatic wr(input logic [7:0] b, input bit accept);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic stop_wr();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && busy === 1'b0 && empty === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " drain"}, 32'(n < 3000), 32'd1);
  endtask

  initial begin : stim
    logic [7:0] hello [5];
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values, then 100 idle cycles
    chk("rst txd", 32'(txd), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst usedw", 32'(usedw), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle state", 32'({txd, busy, empty, usedw}), 32'({1'b1, 1'b0, 1'b1, 3'd0}));
    end

    // Single byte 0x55: cycle-exact waveform and busy fall
    wr(8'h55, 1'b1);
    stop_wr();
    for (int k = 1; k <= 82; k++) begin
      @(negedge clk);
      chk("single txd", 32'(txd), 32'(exp_txd(k, 8'h55)));
      chk("single busy", 32'(busy), 32'(k < 82));
    end
    drain("single");

    // "Hello" burst on consecutive cycles
    start_q.delete();
    for (int i = 0; i < 5; i++) wr(hello[i], 1'b1);
    stop_wr();
    chk("hello usedw peak", 32'(usedw), 32'd4);
    chk("hello full", 32'(full), 32'd1);
    drain("hello");
    chk("hello frames", 32'(start_q.size()), 32'd5);
    for (int i = 1; i < start_q.size(); i++)
      chk("hello spacing", 32'(start_q[i] - start_q[i-1]), 32'd82);

    // Fill while frame 1 is in flight, then one dropped write
    wr(8'h01, 1'b1);
    stop_wr();
    repeat (2) @(negedge clk);
    chk("fill busy", 32'(busy), 32'd1);
    for (int i = 2; i <= 5; i++) wr(8'(i), 1'b1);
    wr(8'hEE, 1'b0);
    stop_wr();
    chk("fill overflow", 32'(overflow), 32'd1);
    chk("fill usedw", 32'(usedw), 32'd4);
    chk("fill full", 32'(full), 32'd1);
    drain("fill");
    chk("overflow sticky", 32'(overflow), 32'd1);

    // Write coinciding with an IDLE pop at usedw=2
    wr(8'h81, 1'b1);
    wr(8'h7E, 1'b1);
    wr(8'hC3, 1'b1);
    stop_wr();
    repeat (79) @(negedge clk);
    wr(8'h18, 1'b1);
    chk("pre-pop usedw", 32'(usedw), 32'd2);
    chk("pre-pop busy", 32'(busy), 32'd0);
    stop_wr();
    chk("simul usedw", 32'(usedw), 32'd2);
    chk("simul busy", 32'(busy), 32'd1);
    drain("simul");

    // Reset during DATA bit 3 of 0xA5 with two bytes queued
    wr(8'hA5, 1'b1);
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    stop_wr();
    repeat (35) @(negedge clk);
    chk("bit3 of A5", 32'(txd), 32'd0);
    chk("queued before rst", 32'(usedw), 32'd2);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst txd", 32'(txd), 32'd1);
    chk("midrst empty", 32'(empty), 32'd1);
    chk("midrst overflow", 32'(overflow), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst usedw", 32'(usedw), 32'd0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("post-rst quiet", 32'({txd, busy}), 32'({1'b1, 1'b0}));
    end
    wr(8'h3C, 1'b1);
    stop_wr();
    drain("post-rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
